// File: rtl/up_count_4_tff.sv
`default_nettype none
// ============================================================================
//  Module      : up_count_4_tff_stage
//  Description : Single toggle flip-flop stage (T tied high) with an
//                asynchronous active-low clear. It toggles on every rising
//                edge of its own clock input.
//  Ports       : clk_i   - stage clock (system clock or inverted lower bit)
//                rst_ni  - asynchronous active-low clear
//                q_o     - stage state
//  Revision    : 1.0 - initial release
// ============================================================================
module up_count_4_tff_stage (
  input  logic clk_i,
  input  logic rst_ni,
  output logic q_o
);

  // State register is deliberately named q so it can be deposited
  // hierarchically (t0.q .. t3.q) instead of going through reset.
  logic q;
  logic q_d;

  assign q_d = ~q;

  // The clear branch comes first, so a stage whose clock edge is produced
  // by a lower stage being cleared stays cleared rather than toggling.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q <= 1'b0;
    end else begin
      q <= q_d;
    end
  end

  assign q_o = q;

endmodule

// ============================================================================
//  Module      : up_count_4_tff
//  Description : Ripple (asynchronous) binary up-counter. Stage 0 toggles on
//                the rising edge of clk; every later stage toggles on the
//                falling edge of the stage below it (rising edge of its
//                inverse), which is the carry. Counts modulo 2**WIDTH with
//                no enable, load or terminal-count flag.
//  Parameters  : WIDTH   - number of stages / counter width (minimum 4)
//  Ports       : clk     - system clock, clocks stage 0 only
//                rst_n   - asynchronous active-low clear of every stage
//                q       - count value, q[0] is the LSB
//  Revision    : 1.0 - initial release
// ============================================================================
module up_count_4_tff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] q
);

  // Stage outputs and the inverted bits used as clocks for the next stage.
  logic [WIDTH-1:0] w_stage_q;
  logic [WIDTH-1:0] w_stage_clk;

  assign w_stage_clk[0] = clk;

  // Stage i is clocked by ~q[i-1]: a 1->0 on the lower bit is a carry.
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_carry_clk
      assign w_stage_clk[gi] = ~w_stage_q[gi-1];
    end
  endgenerate

  // The first four stages carry fixed instance names t0..t3 so their state
  // registers are reachable by hierarchical path.
  up_count_4_tff_stage t0 (
    .clk_i  (w_stage_clk[0]),
    .rst_ni (rst_n),
    .q_o    (w_stage_q[0])
  );

  up_count_4_tff_stage t1 (
    .clk_i  (w_stage_clk[1]),
    .rst_ni (rst_n),
    .q_o    (w_stage_q[1])
  );

  up_count_4_tff_stage t2 (
    .clk_i  (w_stage_clk[2]),
    .rst_ni (rst_n),
    .q_o    (w_stage_q[2])
  );

  up_count_4_tff_stage t3 (
    .clk_i  (w_stage_clk[3]),
    .rst_ni (rst_n),
    .q_o    (w_stage_q[3])
  );

  // Any stages beyond the fourth for wider configurations.
  generate
    for (genvar gj = 4; gj < WIDTH; gj++) begin : g_upper_stage
      up_count_4_tff_stage tn (
        .clk_i  (w_stage_clk[gj]),
        .rst_ni (rst_n),
        .q_o    (w_stage_q[gj])
      );
    end
  endgenerate

  // Output is the raw stage state; it is not re-registered.
  assign q = w_stage_q;

endmodule
`default_nettype wire

// File: tb/tb_up_count_4_tff.sv
`default_nettype none
// ============================================================================
//  Module      : tb_up_count_4_tff
//  Description : Directed self-checking bench for the 4-bit ripple counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_up_count_4_tff;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] q;

  int total = 0;
  int bad   = 0;

  // Per-bit transition counters, updated on every settled or delta change.
  int tc0 = 0;
  int tc1 = 0;
  int tc2 = 0;
  int tc3 = 0;
  int s0, s1, s2, s3;

  up_count_4_tff #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (q)
  );

  always #5 clk = ~clk;

  always @(q[0]) tc0++;
  always @(q[1]) tc1++;
  always @(q[2]) tc2++;
  always @(q[3]) tc3++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s0 = tc0; s1 = tc1; s2 = tc2; s3 = tc3;
  endtask

  initial begin
    // Reset held for three clock cycles: q stays 0 throughout.
    rst_n = 1'b0;
    #1;
    chk("rst_t0", {28'd0, q}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_hold", {28'd0, q}, 32'd0);
    end

    // Release between edges; first edge -> 1, second -> 2.
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("first_edge", {28'd0, q}, 32'd1);
    tick();
    chk("second_edge", {28'd0, q}, 32'd2);

    // Free run through the 15 -> 0 wrap; settled value is N mod 16.
    for (int n = 3; n <= 20; n++) begin
      tick();
      chk("run", {28'd0, q}, n % 16);
    end

    // Divider: over 32 edges bits toggle 32/16/8/4 times.
    snap();
    for (int i = 0; i < 32; i++) tick();
    chk("div_q0", tc0 - s0, 32);
    chk("div_q1", tc1 - s1, 16);
    chk("div_q2", tc2 - s2, 8);
    chk("div_q3", tc3 - s3, 4);
    chk("div_val", {28'd0, q}, 32'd4);

    // Wrap: 15 -> 0 with each bit toggling exactly once.
    for (int i = 0; i < 11; i++) tick();
    chk("pre_wrap", {28'd0, q}, 32'd15);
    snap();
    tick();
    chk("wrap", {28'd0, q}, 32'd0);
    chk("wrap_t0", tc0 - s0, 1);
    chk("wrap_t1", tc1 - s1, 1);
    chk("wrap_t2", tc2 - s2, 1);
    chk("wrap_t3", tc3 - s3, 1);

    // Asynchronous reset at 0111 between edges: clears at once and the
    // clearing of the low bits must not toggle bit 3.
    for (int i = 0; i < 7; i++) tick();
    chk("pre_arst", {28'd0, q}, 32'd7);
    @(negedge clk);
    snap();
    rst_n = 1'b0;
    #1;
    chk("arst_val", {28'd0, q}, 32'd0);
    chk("arst_t0", tc0 - s0, 1);
    chk("arst_t1", tc1 - s1, 1);
    chk("arst_t2", tc2 - s2, 1);
    chk("arst_t3", tc3 - s3, 0);
    tick();
    chk("arst_hold", {28'd0, q}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst_rel", {28'd0, q}, 32'd1);
    tick();
    chk("arst_rel2", {28'd0, q}, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
